stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel, 1..64.
REQ-002 SHALL have parameter N, default 4: input channel count, 2..16.
REQ-003 SHALL have parameter SELW, default 2: select/channel-index width, equal to ceil(log2(N)).
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1: 0 = fixed select by sel, 1 = round-robin.
REQ-007 SHALL have port sel, input, SELW: channel index used in fixed mode.
REQ-008 SHALL have port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid, input, N: per-channel valid.
REQ-010 SHALL have port in_ready, output, N: per-channel ready; combinational.
REQ-011 SHALL have port out_data, output, WIDTH: registered selected data.
REQ-012 SHALL have port out_ch, output, SELW: registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1: registered output valid.
REQ-014 SHALL have port out_ready, input, 1: downstream ready.

Function
REQ-015 A transfer on channel i SHALL occur on a cycle where in_valid[i] && in_ready[i]; output transfer on out_valid && out_ready.
REQ-016 load = !out_valid || out_ready; in_ready SHALL be one-hot or zero, in_ready[i] = load && grant[i].
REQ-017 Fixed mode: grant SHALL be bit sel when in_valid[sel] is set and sel < N; otherwise zero. sel >= N SHALL grant nothing.
REQ-018 Round-robin mode: grant SHALL go to the first valid channel searching ptr+1, ptr+2, ... modulo N, where ptr is the last granted channel.
REQ-019 ptr SHALL update to the granted index on every input transfer, in either mode; it SHALL otherwise hold.
REQ-020 A channel asserting valid continuously in round-robin mode SHALL wait at most N-1 transfers for a grant.
REQ-021 On an input transfer, out_data, out_ch and out_valid=1 SHALL load on the next edge; latency is 1 cycle.
REQ-022 If load is set and no channel is granted, out_valid SHALL clear on the next edge; out_data and out_ch SHALL hold.
REQ-023 If out_valid && !out_ready, out_data, out_ch and out_valid SHALL hold, and in_ready SHALL be all zero.
REQ-024 Back-to-back transfers SHALL sustain one per cycle while out_ready stays high.
REQ-025 mode and sel SHALL be sampled combinationally each cycle; a change affects only the grant in that same cycle and never alters a held output.
REQ-026 Wrap-around: ptr = N-1 SHALL search from channel 0.

Reset
REQ-027 While rst is high at an edge: out_valid=0, out_data=0, out_ch=0, ptr=N-1; in_ready SHALL be zero while rst is high.
REQ-028 Reset asserted mid-stream SHALL discard any held output word; no input transfer occurs in that cycle.
REQ-029 After reset in round-robin mode, the first grant with all channels valid SHALL be channel 0.

Verification
REQ-030 Fixed mode, N=4, WIDTH=8, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1, sel stepping 0,1,2,3 -> out_data 11,22,33,44 one cycle after each step, out_ch = sel.
REQ-031 Round-robin mode, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; in_ready one-hot each cycle.
REQ-032 Round-robin mode, in_valid=4'b1010 -> out_ch alternates 1,3; channels 0 and 2 are never granted.
REQ-033 out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0; on release, the next word follows with no gap.
REQ-034 Fixed mode, sel=2, in_valid[2]=0 -> in_ready=0; out_valid drops after the pending word drains.
REQ-035 rst pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0; the first round-robin grant after reset is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream multiplexer with fixed-select and round-robin arbitration
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gidx;
    logic [SELW-1:0]  cand;
    logic             found;
    logic             load;
    logic             xfer;
    int               sum;
    logic [WIDTH-1:0] ch_data [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Round-robin searches ptr+1 .. ptr+N so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        sum   = 0;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                sum = int'(ptr) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                cand = SELW'(sum);
                if (!found && in_valid[cand]) begin
                    found = 1'b1;
                    gidx  = cand;
                end
            end
        end else begin
            if (int'(sel) < N && in_valid[sel]) begin
                found = 1'b1;
                gidx  = sel;
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign xfer     = load && found && !rst;
    assign in_ready = xfer ? (N'(1) << gidx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(N - 1);
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[gidx];
                out_ch    <= gidx;
                ptr       <= gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard bench for stream_mux_rr
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 mode = 1'b0;
    logic [SELW-1:0]      sel = '0;
    logic [N*WIDTH-1:0]   in_data = '0;
    logic [N-1:0]         in_valid = '0;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready = 1'b0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [SELW+WIDTH-1:0] sb [$];
    int                    m_ptr = N - 1;
    logic                  m_valid = 1'b0;
    logic                  m_xfer = 1'b0;
    logic [N-1:0]          exp_ready = '0;

    // Drive one cycle of inputs after the falling edge and advance the reference model.
    task automatic drive(input logic md, input logic [SELW-1:0] s, input logic [N-1:0] v, input logic ordy);
        int g;
        int c;
        @(negedge clk);
        mode = md; sel = s; in_valid = v; out_ready = ordy;
        g = -1;
        if (!md) begin
            if (int'(s) < N && v[s]) g = int'(s);
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_ready = '0;
        m_xfer = 1'b0;
        if (!m_valid || ordy) begin
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                m_xfer = 1'b1;
                m_ptr = g;
                sb.push_back({SELW'(g), in_data[g*WIDTH +: WIDTH]});
            end
            m_valid = (g >= 0);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input logic ordy);
        @(negedge clk);
        rst = 1'b1; mode = 1'b1; in_valid = '1; out_ready = ordy;
        #1;
        n_cmp++;
        if (in_ready !== '0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tick();
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== '0)
            begin n_bad++; $display("FAIL reset_outputs: got v=%b ch=%0d d=%h expected all 0", out_valid, out_ch, out_data); end
        rst = 1'b0;
        m_ptr = N - 1; m_valid = 1'b0; sb.delete();
    endtask

    task automatic test_fixed();
        logic [SELW+WIDTH-1:0] e;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int s = 0; s < N; s++) begin
            drive(1'b0, SELW'(s), 4'b1111, 1'b1);
            n_cmp++;
            if (in_ready !== exp_ready) begin n_bad++; $display("FAIL fixed_in_ready: got %b expected %b", in_ready, exp_ready); end
            tick();
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b1, e})
                begin n_bad++; $display("FAIL fixed_sb: got ch=%0d d=%h expected %h", out_ch, out_data, e); end
            n_cmp++;
            if (out_data !== WIDTH'(8'h11 * (s + 1)) || out_ch !== SELW'(s))
                begin n_bad++; $display("FAIL fixed_table: got ch=%0d d=%h expected ch=%0d", out_ch, out_data, s); end
        end
    endtask

    task automatic test_rr();
        logic [SELW+WIDTH-1:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, '0, 4'b1111, 1'b1);
            n_cmp++;
            if (in_ready !== exp_ready || !$onehot(in_ready))
                begin n_bad++; $display("FAIL rr_in_ready: got %b expected %b", in_ready, exp_ready); end
            tick();
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b1, e} || out_ch !== SELW'(i % N))
                begin n_bad++; $display("FAIL rr_order: got ch=%0d d=%h expected ch=%0d", out_ch, out_data, i % N); end
        end
    endtask

    task automatic test_rr_sparse();
        logic [SELW+WIDTH-1:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, '0, 4'b1010, 1'b1);
            n_cmp++;
            if (in_ready !== exp_ready || (in_ready & 4'b0101) !== '0)
                begin n_bad++; $display("FAIL sparse_in_ready: got %b expected %b", in_ready, exp_ready); end
            tick();
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b1, e} || out_ch !== ((i % 2) ? 2'd3 : 2'd1))
                begin n_bad++; $display("FAIL sparse_order: got ch=%0d expected ch=%0d", out_ch, (i % 2) ? 3 : 1); end
        end
    endtask

    task automatic test_back_pressure();
        logic [SELW+WIDTH-1:0] e;
        logic [SELW+WIDTH-1:0] held;
        drive(1'b1, '0, 4'b1111, 1'b1);
        tick();
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        held = {out_ch, out_data};
        n_cmp++;
        if ({out_valid, held} !== {1'b1, e}) begin n_bad++; $display("FAIL bp_load: got %h expected %h", held, e); end
        // mode/sel wiggle during the stall must not disturb the held word
        for (int i = 0; i < 3; i++) begin
            drive(i[0], SELW'(i), 4'b1111, 1'b0);
            n_cmp++;
            if (in_ready !== '0 || exp_ready !== '0) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            tick();
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b1, held})
                begin n_bad++; $display("FAIL bp_hold: got ch=%0d d=%h expected %h", out_ch, out_data, held); end
        end
        drive(1'b1, '0, 4'b1111, 1'b1);
        n_cmp++;
        if (in_ready !== exp_ready || in_ready === '0) begin n_bad++; $display("FAIL bp_release: got %b expected %b", in_ready, exp_ready); end
        tick();
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== {1'b1, e}) begin n_bad++; $display("FAIL bp_next: got ch=%0d d=%h expected %h", out_ch, out_data, e); end
    endtask

    task automatic test_fixed_idle();
        logic [SELW+WIDTH-1:0] e;
        drive(1'b0, 2'd2, 4'b1111, 1'b1);
        tick();
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== {1'b1, e}) begin n_bad++; $display("FAIL idle_load: got ch=%0d d=%h expected %h", out_ch, out_data, e); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'd2, 4'b1011, 1'b1);
            n_cmp++;
            if (in_ready !== '0 || m_xfer) begin n_bad++; $display("FAIL idle_in_ready: got %b expected 0", in_ready); end
            tick();
            n_cmp++;
            if ({out_valid, out_ch, out_data} !== {1'b0, e})
                begin n_bad++; $display("FAIL idle_drain: got v=%b ch=%0d d=%h expected v=0 %h", out_valid, out_ch, out_data, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [SELW+WIDTH-1:0] e;
        drive(1'b1, '0, 4'b1111, 1'b1);
        tick();
        drive(1'b1, '0, 4'b1111, 1'b0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got v=%b expected 1", out_valid); end
        test_reset(1'b0);
        drive(1'b1, '0, 4'b1111, 1'b1);
        n_cmp++;
        if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b expected 0001", in_ready); end
        tick();
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if ({out_valid, out_ch, out_data} !== {1'b1, e} || out_ch !== 2'd0)
            begin n_bad++; $display("FAIL mid_first_word: got ch=%0d d=%h expected ch=0 %h", out_ch, out_data, e); end
    endtask

    initial begin
        test_reset(1'b1);
        test_fixed();
        test_reset(1'b1);
        test_rr();
        test_rr_sparse();
        test_back_pressure();
        test_fixed_idle();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
